// File: rtl/shexseg_scan_if.sv
// Bundles the display data inputs and the scanned LED outputs of shexseg_scan.
// master drives value/control and observes the pins; slave is the scanner.
interface shexseg_scan_if #(
  parameter int NDIGITS  = 4,
  parameter int BRIGHT_W = 3
);
  logic [4*NDIGITS-1:0] value;
  logic [NDIGITS-1:0]   dots;
  logic [NDIGITS-1:0]   digit_en;
  logic                 lz_suppress;
  logic [BRIGHT_W-1:0]  brightness;
  logic [7:0]           osegment;
  logic [NDIGITS-1:0]   odigit;
  logic                 frame_start;

  modport master (
    output value, dots, digit_en, lz_suppress, brightness,
    input  osegment, odigit, frame_start
  );

  modport slave (
    input  value, dots, digit_en, lz_suppress, brightness,
    output osegment, odigit, frame_start
  );
endinterface

// File: rtl/shexseg_scan.sv
// Time-multiplexed hex 7-segment scanner with per-frame snapshot, leading-zero
// blanking, PWM brightness and a dark guard cycle at the start of every slot.
module shexseg_scan #(
  parameter int NDIGITS  = 4,
  parameter int SCAN_DIV = 1000,
  parameter int BRIGHT_W = 3
) (
  input  logic          clk,
  input  logic          reset,
  shexseg_scan_if.slave bus
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int CW = PW + BRIGHT_W + 1;
  localparam logic [PW-1:0] PRES_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGITS - 1);
  localparam logic [CW-1:0] ON_MAX    = CW'(SCAN_DIV - 1);

  logic [PW-1:0]          pres_r;
  logic [IW-1:0]          idx_r;
  logic                   load_pend_r;
  logic [4*NDIGITS-1:0]   value_r;
  logic [NDIGITS-1:0]     dots_r;
  logic [NDIGITS-1:0]     en_r;
  logic                   lz_r;
  logic [BRIGHT_W-1:0]    bright_r;
  logic [7:0]             osegment_r;
  logic [NDIGITS-1:0]     odigit_r;
  logic                   frame_start_r;

  logic                   slot_end_s;
  logic                   load_s;
  logic [CW-1:0]          on_raw_s;
  logic [CW-1:0]          on_cnt_s;
  logic [NDIGITS:0]       zero_s;
  logic [3:0]             nib_s;
  logic                   suppress_s;
  logic                   lit_s;
  logic [7:0]             seg_next_s;
  logic [NDIGITS-1:0]     dig_next_s;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hEE;  4'h1: seg = 8'h60;  4'h2: seg = 8'hCD;  4'h3: seg = 8'hE9;
      4'h4: seg = 8'h63;  4'h5: seg = 8'hAB;  4'h6: seg = 8'hAF;  4'h7: seg = 8'hE0;
      4'h8: seg = 8'hEF;  4'h9: seg = 8'hEB;  4'hA: seg = 8'hE7;  4'hB: seg = 8'h2F;
      4'hC: seg = 8'h8E;  4'hD: seg = 8'h6D;  4'hE: seg = 8'h8F;  4'hF: seg = 8'h87;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

  assign slot_end_s = (pres_r == PRES_LAST);
  assign load_s     = load_pend_r || (slot_end_s && (idx_r == IDX_LAST));

  // Prescaler and digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pres_r <= '0;
      idx_r  <= '0;
    end else if (slot_end_s) begin
      pres_r <= '0;
      idx_r  <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
    end else begin
      pres_r <= pres_r + PW'(1);
    end
  end

  // Frame snapshot; shadows only change at a frame boundary so a frame never tears
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_pend_r   <= 1'b1;
      frame_start_r <= 1'b0;
      value_r       <= '0;
      dots_r        <= '0;
      en_r          <= '0;
      lz_r          <= 1'b0;
      bright_r      <= '0;
    end else begin
      load_pend_r   <= 1'b0;
      frame_start_r <= load_s;
      if (load_s) begin
        value_r  <= bus.value;
        dots_r   <= bus.dots;
        en_r     <= bus.digit_en;
        lz_r     <= bus.lz_suppress;
        bright_r <= bus.brightness;
      end
    end
  end

  // On-time per slot, clamped so pres==0 stays dark and at least one clock is lit
  always_comb begin
    on_raw_s = ((CW'(bright_r) + CW'(1)) * CW'(SCAN_DIV)) >> BRIGHT_W;
    if (on_raw_s < CW'(1)) begin
      on_cnt_s = CW'(1);
    end else if (on_raw_s > ON_MAX) begin
      on_cnt_s = ON_MAX;
    end else begin
      on_cnt_s = on_raw_s;
    end
  end

  // Next segment/digit pattern from the current slot and the shadow data
  always_comb begin
    zero_s[NDIGITS] = 1'b1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      zero_s[i] = zero_s[i+1] && (value_r[4*i +: 4] == 4'h0);
    end
    nib_s      = 4'(value_r >> {idx_r, 2'b00});
    suppress_s = lz_r && (idx_r != '0) && zero_s[{1'b0, idx_r}];
    lit_s      = (pres_r != '0) && (CW'(pres_r) <= on_cnt_s) && en_r[idx_r];
    if (lit_s) begin
      seg_next_s = (suppress_s ? 8'h00 : seg_decode(nib_s)) |
                   (dots_r[idx_r] ? 8'h10 : 8'h00);
      dig_next_s = NDIGITS'(1) << idx_r;
    end else begin
      seg_next_s = 8'h00;
      dig_next_s = '0;
    end
  end

  // Registered LED pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      osegment_r <= 8'h00;
      odigit_r   <= '0;
    end else begin
      osegment_r <= seg_next_s;
      odigit_r   <= dig_next_s;
    end
  end

  assign bus.osegment    = osegment_r;
  assign bus.odigit      = odigit_r;
  assign bus.frame_start = frame_start_r;
endmodule

// File: tb/tb_shexseg_scan.sv
// Directed table-driven bench for shexseg_scan (NDIGITS=4, SCAN_DIV=8, BRIGHT_W=3).
module tb_shexseg_scan;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  shexseg_scan_if #(.NDIGITS(4), .BRIGHT_W(3)) bus ();

  shexseg_scan #(.NDIGITS(4), .SCAN_DIV(8), .BRIGHT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dots;
    logic [3:0]  en;
    logic        lz;
    logic [2:0]  bright;
    logic [31:0] segs;   // expected lit pattern, digit i in segs[8*i +: 8]
    int          on_cnt;
  } vec_t;

  vec_t tbl [0:10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.value       = v.value;
    bus.dots        = v.dots;
    bus.digit_en    = v.en;
    bus.lz_suppress = v.lz;
    bus.brightness  = v.bright;
  endtask

  task automatic sync_frame(input string name);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (bus.frame_start) got = 1'b1;
    end
    chk({name, "_sync"}, 32'(got), 32'd1);
  endtask

  // Checks one full frame starting with the first negedge after the frame_start sample
  task automatic observe(input vec_t v, input string name, input bit chg, input vec_t nv);
    int         d;
    int         p;
    bit         lit;
    logic [7:0] eseg;
    logic [3:0] edig;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      d    = k / 8;
      p    = k % 8;
      lit  = (p >= 1) && (p <= v.on_cnt) && v.en[d];
      eseg = lit ? v.segs[8*d +: 8] : 8'h00;
      edig = lit ? (4'b0001 << d) : 4'b0000;
      chk($sformatf("%s_seg_k%0d", name, k), 32'(bus.osegment), 32'(eseg));
      chk($sformatf("%s_dig_k%0d", name, k), 32'(bus.odigit), 32'(edig));
      chk($sformatf("%s_fs_k%0d", name, k), 32'(bus.frame_start), 32'(k == 31));
      if (chg && k == 10) apply(nv);
    end
  endtask

  initial begin
    vec_t b;
    tests = 0;
    fails = 0;
    //             value     dots     en       lz    br    segs {d3,d2,d1,d0}  on
    tbl[0]  = '{16'h12A0, 4'b0000, 4'b1111, 1'b0, 3'd7, 32'h60CDE7EE, 7};
    tbl[1]  = '{16'h0005, 4'b0000, 4'b1111, 1'b1, 3'd7, 32'h000000AB, 7};
    tbl[2]  = '{16'h0000, 4'b0000, 4'b1111, 1'b1, 3'd7, 32'h000000EE, 7};
    tbl[3]  = '{16'h12A0, 4'b0000, 4'b1111, 1'b0, 3'd1, 32'h60CDE7EE, 2};
    tbl[4]  = '{16'h12A0, 4'b0000, 4'b1111, 1'b0, 3'd0, 32'h60CDE7EE, 1};
    tbl[5]  = '{16'h12A0, 4'b0100, 4'b1111, 1'b0, 3'd7, 32'h60DDE7EE, 7};
    tbl[6]  = '{16'h12A0, 4'b0100, 4'b1011, 1'b0, 3'd7, 32'h60DDE7EE, 7};
    tbl[7]  = '{16'h89BC, 4'b1001, 4'b1111, 1'b1, 3'd3, 32'hFFEB2F9E, 4};
    tbl[8]  = '{16'h0F00, 4'b1000, 4'b1111, 1'b1, 3'd7, 32'h1087EEEE, 7};
    tbl[9]  = '{16'h3E64, 4'b0000, 4'b1111, 1'b0, 3'd7, 32'hE98FAF63, 7};
    tbl[10] = '{16'hDEF7, 4'b1111, 4'b0000, 1'b0, 3'd7, 32'h00000000, 7};
    b       = '{16'h0005, 4'b0000, 4'b1111, 1'b0, 3'd7, 32'hEEEEEEAB, 7};

    // Reset, release, first snapshot and first lit clock
    clk   = 1'b0;
    reset = 1'b1;
    apply(tbl[0]);
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(bus.osegment), 32'h00);
    chk("rst_dig", 32'(bus.odigit), 32'h0);
    chk("rst_fs", 32'(bus.frame_start), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel1_fs", 32'(bus.frame_start), 32'd1);
    chk("rel1_dig", 32'(bus.odigit), 32'h0);
    @(negedge clk);
    chk("rel2_fs", 32'(bus.frame_start), 32'd0);
    chk("rel2_seg", 32'(bus.osegment), 32'hEE);
    chk("rel2_dig", 32'(bus.odigit), 32'h1);

    for (int i = 0; i < 11; i++) begin
      apply(tbl[i]);
      sync_frame($sformatf("v%0d", i));
      observe(tbl[i], $sformatf("v%0d", i), 1'b0, tbl[i]);
    end

    // Mid-frame value change stays hidden until the next frame
    apply(tbl[0]);
    sync_frame("mid");
    observe(tbl[0], "mid_old", 1'b1, b);
    observe(b, "mid_new", 1'b0, b);

    // Asynchronous reset in the middle of a lit slot
    apply(tbl[0]);
    sync_frame("arst");
    repeat (3) @(negedge clk);
    chk("arst_pre_dig", 32'(bus.odigit), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_seg", 32'(bus.osegment), 32'h00);
    chk("arst_dig", 32'(bus.odigit), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("arst_rel1_fs", 32'(bus.frame_start), 32'd1);
    chk("arst_rel1_dig", 32'(bus.odigit), 32'h0);
    @(negedge clk);
    chk("arst_rel2_seg", 32'(bus.osegment), 32'hEE);
    chk("arst_rel2_dig", 32'(bus.odigit), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
